// File: rtl/friscv_apb_arbiter_pkg.sv
// Shared constants for the APB round-robin arbiter: FSM encodings and abort read data.
package friscv_apb_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [63:0] ABORT_DATA = '1;

endpackage

// File: rtl/friscv_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
module friscv_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx
);

  always_comb begin
    logic [31:0] idx;
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    // Scan farthest-first so the candidate nearest to ptr is written last and wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + 32'(NREQ) - 32'd1 - k) % 32'(NREQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/friscv_apb_arbiter.sv
// Round-robin arbiter sharing one APB-like slave between NREQ requesters.
// Optional access timeout/abort enabled by defining FRISCV_APB_ARB_TIMEOUT_EN.
module friscv_apb_arbiter
  import friscv_apb_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDRW-1:0]    req_addr,
  input  logic [NREQ*XLEN-1:0]     req_wdata,
  input  logic [NREQ*XLEN/8-1:0]   req_strb,
  output logic [XLEN-1:0]          req_rdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     req_err,
  output logic                     mst_en,
  output logic                     mst_wr,
  output logic [ADDRW-1:0]         mst_addr,
  output logic [XLEN-1:0]          mst_wdata,
  output logic [XLEN/8-1:0]        mst_strb,
  input  logic [XLEN-1:0]          mst_rdata,
  input  logic                     mst_ready
);

  localparam int IDXW  = $clog2(NREQ);
  localparam int STRBW = XLEN / 8;

  logic [1:0]      state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gidx;
  logic [NREQ-1:0] gsel;
  logic [NREQ-1:0] arb_grant;
  logic [IDXW-1:0] arb_idx;

  friscv_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req       (req_en),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef FRISCV_APB_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] tcnt;
  logic            timed_out;
  assign timed_out = (tcnt == CNTW'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign req_err = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      gsel      <= '0;
      mst_en    <= 1'b0;
      mst_wr    <= 1'b0;
      mst_addr  <= '0;
      mst_wdata <= '0;
      mst_strb  <= '0;
      req_rdata <= '0;
      req_ready <= '0;
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
      tcnt      <= '0;
      req_err   <= 1'b0;
`endif
    end else if (srst) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      gsel      <= '0;
      mst_en    <= 1'b0;
      mst_wr    <= 1'b0;
      mst_addr  <= '0;
      mst_wdata <= '0;
      mst_strb  <= '0;
      req_rdata <= '0;
      req_ready <= '0;
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
      tcnt      <= '0;
      req_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_en) begin
            gsel      <= arb_grant;
            gidx      <= arb_idx;
            mst_en    <= 1'b1;
            mst_wr    <= req_wr[arb_idx];
            mst_addr  <= req_addr[arb_idx*ADDRW +: ADDRW];
            mst_wdata <= req_wdata[arb_idx*XLEN +: XLEN];
            mst_strb  <= req_strb[arb_idx*STRBW +: STRBW];
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mst_ready) begin
            mst_en    <= 1'b0;
            req_rdata <= mst_rdata;
            req_ready <= gsel;
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
            req_err   <= 1'b0;
`endif
            state     <= DONE;
          end
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
          else if (timed_out) begin
            mst_en    <= 1'b0;
            req_rdata <= ABORT_DATA[XLEN-1:0];
            req_err   <= 1'b1;
            req_ready <= gsel;
            state     <= DONE;
          end else begin
            tcnt <= tcnt + CNTW'(1);
          end
`endif
        end
        DONE: begin
          // No arbitration here, so the finishing requester's lingering req_en is not re-granted.
          req_ready <= '0;
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
          req_err   <= 1'b0;
`endif
          ptr       <= (gidx == IDXW'(NREQ - 1)) ? '0 : gidx + IDXW'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_apb_arbiter.sv
// Self-checking bench for friscv_apb_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_friscv_apb_arbiter;

  localparam int NREQ  = 4;
  localparam int ADDRW = 16;
  localparam int XLEN  = 32;
  localparam int SW    = XLEN / 8;
  localparam int TMO   = 8;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   srst = 1'b0;
  logic [NREQ-1:0]        req_en = '0;
  logic [NREQ-1:0]        req_wr = '0;
  logic [NREQ*ADDRW-1:0]  req_addr = '0;
  logic [NREQ*XLEN-1:0]   req_wdata = '0;
  logic [NREQ*SW-1:0]     req_strb = '0;
  logic [XLEN-1:0]        req_rdata;
  logic [NREQ-1:0]        req_ready;
  logic                   req_err;
  logic                   mst_en;
  logic                   mst_wr;
  logic [ADDRW-1:0]       mst_addr;
  logic [XLEN-1:0]        mst_wdata;
  logic [SW-1:0]          mst_strb;
  logic [XLEN-1:0]        mst_rdata = '0;
  logic                   mst_ready = 1'b0;

  friscv_apb_arbiter #(
    .NREQ    (NREQ),
    .ADDRW   (ADDRW),
    .XLEN    (XLEN),
    .TIMEOUT (TMO)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .req_en    (req_en),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_rdata (req_rdata),
    .req_ready (req_ready),
    .req_err   (req_err),
    .mst_en    (mst_en),
    .mst_wr    (mst_wr),
    .mst_addr  (mst_addr),
    .mst_wdata (mst_wdata),
    .mst_strb  (mst_strb),
    .mst_rdata (mst_rdata),
    .mst_ready (mst_ready)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // transaction-level model of the arbiter
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_g = 0, m_ptr = 0, m_free = 0, m_start = 0;
  bit          m_wr = 0;
  logic [31:0] m_sdata = '0;

  // slave model and knobs
  int          s_age = 0, s_delay = 1, s_cnt = 0;
  bit          rand_delay = 0, stray_en = 0, use_fix = 0;
  logic [31:0] fix_data = '0;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_strb;

  // requester knobs
  bit              auto_rand = 0;
  logic [NREQ-1:0] keep = '0;

  int obs_q[$];
  int obs_cyc_q[$];

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_free = 0;
  endtask

  task automatic slave_reset();
    mst_ready = 1'b0; s_age = 0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_mst_en"}, mst_en, 0);
    check({tag, "_mst_wr"}, mst_wr, 0);
    check({tag, "_mst_addr"}, mst_addr, 0);
    check({tag, "_mst_wdata"}, mst_wdata, 0);
    check({tag, "_mst_strb"}, mst_strb, 0);
    check({tag, "_req_rdata"}, req_rdata, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_req_err"}, req_err, 0);
  endtask

  task automatic model_cycle();
    logic [NREQ-1:0] exp_rdy;
    bit done, abort, found;
    int g;
    exp_rdy = '0; done = 0; abort = 0; found = 0; g = 0;
    if (m_busy && mst_ready) done = 1;
`ifdef FRISCV_APB_ARB_TIMEOUT_EN
    else if (m_busy && cyc == m_start + TMO + 1) begin done = 1; abort = 1; end
`endif
    if (done) begin
      exp_rdy[m_g] = 1'b1;
      m_busy = 0;
      m_ptr  = (m_g + 1) % NREQ;
      m_free = cyc + 2;
      if (abort) begin
        check("abort_data", req_rdata, 32'hFFFF_FFFF);
        check("abort_err", req_err, 1);
      end else begin
        if (!m_wr) check("rd_data", req_rdata, m_sdata);
        check("err", req_err, 0);
      end
    end else if (!m_busy && cyc >= m_free && req_en != '0) begin
      for (int k = 0; k < NREQ; k++)
        if (!found && req_en[(m_ptr + k) % NREQ]) begin
          g = (m_ptr + k) % NREQ;
          found = 1;
        end
      m_busy = 1; m_g = g; m_start = cyc; m_wr = req_wr[g];
      check("mst_wr", mst_wr, req_wr[g]);
      check("mst_addr", mst_addr, req_addr[g*ADDRW +: ADDRW]);
      check("mst_wdata", mst_wdata, req_wdata[g*XLEN +: XLEN]);
      check("mst_strb", mst_strb, req_strb[g*SW +: SW]);
    end
    check("mst_en", mst_en, m_busy);
    check("req_ready", req_ready, exp_rdy);
  endtask

  task automatic slave_drive();
    if (mst_ready) begin
      mst_ready = 1'b0;
      s_age = 0;
    end else if (mst_en) begin
      s_age++;
      if (s_age == 1) begin
        s_cnt++;
        s_wr = mst_wr; s_addr = mst_addr; s_wdata = mst_wdata; s_strb = mst_strb;
        if (rand_delay) s_delay = $urandom_range(1, 4);
      end
      if (s_age == s_delay + 1) begin
        m_sdata   = use_fix ? fix_data : $urandom;
        mst_rdata = m_sdata;
        mst_ready = 1'b1;
      end
    end else begin
      s_age = 0;
      if (stray_en && $urandom_range(0, 7) == 0) begin
        mst_ready = 1'b1;
        mst_rdata = $urandom;
      end
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [15:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    req_en[i] = 1'b1;
    req_wr[i] = wr;
    req_addr[i*ADDRW +: ADDRW] = addr;
    req_wdata[i*XLEN +: XLEN]  = data;
    req_strb[i*SW +: SW]       = strb;
  endtask

  task automatic new_payload(input int i);
    set_req(i, 1'($urandom), 16'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic req_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        if (keep[i] || (auto_rand && $urandom_range(0, 1) == 1)) new_payload(i);
        else req_en[i] = 1'b0;
      end else if (auto_rand && !req_en[i] && $urandom_range(0, 3) == 0) begin
        new_payload(i);
      end
    end
  endtask

  task automatic step();
    @(posedge aclk); #1; cyc++;
    if (srst) begin
      model_reset(); slave_reset(); reset_check("srst");
    end else begin
      model_cycle();
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) begin obs_q.push_back(i); obs_cyc_q.push_back(cyc); end
    slave_drive();
    req_drive();
  endtask

  task automatic run_xfers(input int n, input int budget, input string tag);
    int target, k;
    target = obs_q.size() + n; k = 0;
    while (obs_q.size() < target && k < budget) begin step(); k++; end
    check({tag, "_budget"}, obs_q.size() >= target, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    keep = '0; auto_rand = 0;
    while ((req_en != '0 || m_busy) && k < 200) begin step(); k++; end
    check("drain", (req_en == '0) && !m_busy, 1);
    repeat (2) step();
  endtask

  task automatic do_srst();
    req_en = '0;
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0, mark;
    repeat (2) @(posedge aclk);
    #1;
    reset_check("por");
    aresetn = 1'b1;

    // single read by requester 1
    use_fix = 1; fix_data = 32'h1234_5678; s_delay = 1;
    t0 = cyc;
    set_req(1, 1'b0, 16'h0008, 32'h0, 4'h0);
    run_xfers(1, 20, "rd");
    check("rd_who", obs_q[$], 1);
    check("rd_lat", obs_cyc_q[$] - t0, 3);
    check("rd_value", req_rdata, 32'h1234_5678);
    drain();

    // single write by requester 0
    mark = s_cnt;
    set_req(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'b0011);
    run_xfers(1, 20, "wr");
    check("wr_who", obs_q[$], 0);
    drain();
    check("wr_count", s_cnt - mark, 1);
    check("wr_wr", s_wr, 1);
    check("wr_addr", s_addr, 16'h0010);
    check("wr_wdata", s_wdata, 32'hDEAD_BEEF);
    check("wr_strb", s_strb, 4'b0011);
    use_fix = 0;

    // all four requesting continuously
    do_srst();
    mark = obs_q.size();
    keep = '1;
    for (int i = 0; i < NREQ; i++) new_payload(i);
    run_xfers(8, 60, "rr");
    for (int k = 0; k < 8; k++) begin
      check("rr_order", obs_q[mark + k], k % NREQ);
      if (k > 0) check("rr_period", obs_cyc_q[mark + k] - obs_cyc_q[mark + k - 1], 4);
    end
    drain();

    // requester 0 re-requesting back-to-back while requester 2 waits
    do_srst();
    mark = obs_q.size();
    keep = 4'b0101;
    new_payload(0); new_payload(2);
    run_xfers(4, 40, "b2b");
    for (int k = 0; k < 4; k++) check("b2b_order", obs_q[mark + k], (k % 2) * 2);
    drain();

    // req_en dropped while granted: transfer still completes
    set_req(3, 1'b0, 16'h0040, 32'h0, 4'h0);
    step();
    req_en[3] = 1'b0;
    run_xfers(1, 20, "drop");
    check("drop_who", obs_q[$], 3);
    drain();

    // asynchronous reset in the middle of an access
    s_delay = 50;
    set_req(1, 1'b0, 16'h0020, 32'h0, 4'h0);
    step(); step();
    check("arst_pre_en", mst_en, 1);
    mark = obs_q.size();
    aresetn = 1'b0;
    #1;
    check("arst_en_async", mst_en, 0);
    check("arst_ready_async", req_ready, 0);
    model_reset(); slave_reset();
    @(posedge aclk); #1; cyc++;
    reset_check("arst");
    aresetn = 1'b1;
    check("arst_no_ready", obs_q.size() - mark, 0);
    s_delay = 1;
    run_xfers(1, 20, "arst_after");
    check("arst_after_who", obs_q[$], 1);
    drain();

`ifdef FRISCV_APB_ARB_TIMEOUT_EN
    // silent slave: abort after TIMEOUT cycles in ACCESS
    s_delay = 1000;
    t0 = cyc;
    set_req(0, 1'b0, 16'h0030, 32'h0, 4'h0);
    run_xfers(1, 30, "tmo");
    check("tmo_lat", obs_cyc_q[$] - t0, TMO + 2);
    check("tmo_err", req_err, 1);
    check("tmo_data", req_rdata, 32'hFFFF_FFFF);
    s_delay = 1;
    drain();
`endif

    // random traffic with random slave latency and stray ready pulses
    do_srst();
    auto_rand = 1; rand_delay = 1; stray_en = 1;
    repeat (500) step();
    stray_en = 0;
    drain();
    do_srst();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
